// File: rtl/debug_bridge.sv
// Debug read bridge: services halted-core reads of imem, dmem, regfile
// and PC for the debug controller, with a timeout on memory replies.
module debug_bridge #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] address_bridged,
  output logic [31:0] data_internal,
  output logic        doneSending,
  output logic        err,
  output logic        mem_rd,
  output logic        mem_sel,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  input  logic [31:0] pc_value
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RFREAD, ACK, HOLD
  } state_t;

  state_t      state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [31:0] next_data;
  logic        next_err;
  logic        next_sel;
  logic [29:0] next_addr;
  logic [4:0]  next_rf;
  logic        misaligned;

  assign misaligned = |address_bridged[1:0];

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_data  = data_internal;
    next_err   = err;
    next_sel   = mem_sel;
    next_addr  = mem_addr;
    next_rf    = rf_addr;
    unique case (state)
      IDLE: begin
        if (tx_flag) begin
          unique case (mode)
            3'b001, 3'b010: begin
              if (misaligned) begin
                next_state = ACK;
                next_data  = ERR_WORD;
                next_err   = 1'b1;
              end else begin
                next_state = ISSUE;
                next_sel   = (mode == 3'b010);
                next_addr  = address_bridged[31:2];
              end
            end
            3'b101: begin
              next_state = RFREAD;
              next_rf    = address_bridged[4:0];
            end
            3'b110: begin
              next_state = ACK;
              next_data  = pc_value;
              next_err   = 1'b0;
            end
            default: begin
              next_state = ACK;
              next_data  = ERR_WORD;
              next_err   = 1'b1;
            end
          endcase
        end
      end
      ISSUE: begin
        next_cnt   = '0;
        next_state = WAIT;
      end
      WAIT: begin
        // a reply in the final wait cycle still counts as success
        if (mem_valid) begin
          next_state = ACK;
          next_data  = mem_rdata;
          next_err   = 1'b0;
        end else if (cnt == LAST) begin
          next_state = ACK;
          next_data  = ERR_WORD;
          next_err   = 1'b1;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RFREAD: begin
        next_state = ACK;
        next_data  = rf_rdata;
        next_err   = 1'b0;
      end
      ACK: next_state = HOLD;
      HOLD: begin
        if (!tx_flag) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      cnt           <= '0;
      data_internal <= '0;
      err           <= 1'b0;
      mem_sel       <= 1'b0;
      mem_addr      <= '0;
      rf_addr       <= '0;
      mem_rd        <= 1'b0;
      doneSending   <= 1'b0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      data_internal <= next_data;
      err           <= next_err;
      mem_sel       <= next_sel;
      mem_addr      <= next_addr;
      rf_addr       <= next_rf;
      mem_rd        <= (next_state == ISSUE);
      doneSending   <= (next_state == ACK);
    end
  end

endmodule

// File: tb/tb_debug_bridge.sv
// Randomized bench for debug_bridge against a transaction-level model
// that predicts result, error flag and completion cycle per request.
module tb_debug_bridge;

  localparam int          TIMEOUT  = 255;
  localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        tx_flag = 1'b0;
  logic [2:0]  mode = '0;
  logic [31:0] address_bridged = '0;
  logic [31:0] data_internal;
  logic        doneSending;
  logic        err;
  logic        mem_rd;
  logic        mem_sel;
  logic [29:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic [31:0] pc_value = '0;

  debug_bridge #(.TIMEOUT(TIMEOUT), .ERR_WORD(ERR_WORD)) dut (
    .CLK(CLK), .RST(RST), .tx_flag(tx_flag), .mode(mode),
    .address_bridged(address_bridged), .data_internal(data_internal),
    .doneSending(doneSending), .err(err), .mem_rd(mem_rd),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .pc_value(pc_value)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // environment memories and register file
  bit          ovr_en = 0;
  logic [31:0] ovr_word = '0;
  bit          rf_ovr_en = 0;
  logic [31:0] rf_ovr = '0;
  bit          resp_on = 1;
  int          resp_lat = 1;

  function automatic logic [31:0] mem_word(logic s, logic [29:0] wa);
    if (ovr_en) return ovr_word;
    return ({2'b00, wa} * 32'h9E3779B1) ^ (s ? 32'h5A5A5A5A : 32'h0F0F0F0F);
  endfunction

  function automatic logic [31:0] rf_word(logic [4:0] idx);
    if (rf_ovr_en) return rf_ovr;
    return (32'(idx) + 32'd1) * 32'h01F00F1D;
  endfunction

  assign rf_rdata = rf_word(rf_addr);

  initial begin
    forever begin
      @(negedge CLK);
      if (RST && mem_rd && resp_on) begin
        automatic int          l = resp_lat;
        automatic logic        s = mem_sel;
        automatic logic [29:0] a = mem_addr;
        repeat (l) @(posedge CLK);
        #1;
        mem_valid = 1'b1;
        mem_rdata = mem_word(s, a);
        @(posedge CLK);
        #1;
        mem_valid = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // model: held result plus one pending completion
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  int          p_done = -1;
  int          p_rd = -1;
  int          p_rf = -1;
  logic [31:0] p_data = '0;
  logic        p_err = 1'b0;
  logic        p_sel = 1'b0;
  logic [29:0] p_waddr = '0;
  logic [4:0]  p_rfidx = '0;
  int          done_count = 0;
  int          rd_count = 0;
  int          last_done = -1;

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        m_data = '0;
        m_err  = 1'b0;
        check("rst_data", data_internal, 32'h0);
        check("rst_done", 32'(doneSending), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rd", 32'(mem_rd), 32'h0);
        check("rst_sel", 32'(mem_sel), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rf", 32'(rf_addr), 32'h0);
      end else begin
        if (cyc == p_done) begin
          m_data = p_data;
          m_err  = p_err;
        end
        check("done", 32'(doneSending), 32'(cyc == p_done));
        check("data", data_internal, m_data);
        check("err", 32'(err), 32'(m_err));
        check("mem_rd", 32'(mem_rd), 32'(cyc == p_rd));
        if (cyc == p_rd) begin
          check("mem_sel", 32'(mem_sel), 32'(p_sel));
          check("mem_addr", 32'(mem_addr), 32'(p_waddr));
        end
        if (cyc == p_done && p_rf >= 0)
          check("rf_addr", 32'(rf_addr), 32'(p_rfidx));
        if (doneSending) begin
          done_count++;
          last_done = cyc;
        end
        if (mem_rd) rd_count++;
      end
    end
  end

  task automatic start_xfer(input logic [2:0] md, input logic [31:0] a,
                            input int l, output int p);
    int lat;
    @(posedge CLK);
    #1;
    p = cyc;
    resp_lat = l;
    mode = md;
    address_bridged = a;
    tx_flag = 1'b1;
    p_rd = -1;
    p_rf = -1;
    case (md)
      3'b001, 3'b010: begin
        if (a[1:0] != 2'b00) begin
          lat = 2; p_data = ERR_WORD; p_err = 1'b1;
        end else begin
          p_rd = p + 1;
          p_sel = (md == 3'b010);
          p_waddr = a[31:2];
          if (!resp_on || l > TIMEOUT) begin
            lat = 3 + TIMEOUT; p_data = ERR_WORD; p_err = 1'b1;
          end else begin
            lat = 3 + l; p_data = mem_word(p_sel, a[31:2]); p_err = 1'b0;
          end
        end
      end
      3'b101: begin
        lat = 3; p_rfidx = a[4:0]; p_data = rf_word(a[4:0]); p_err = 1'b0;
        p_rf = p + 2;
      end
      3'b110: begin
        lat = 2; p_data = pc_value; p_err = 1'b0;
      end
      default: begin
        lat = 2; p_data = ERR_WORD; p_err = 1'b1;
      end
    endcase
    p_done = p + lat - 1;
  endtask

  task automatic finish_xfer(input int hold, input bit early);
    @(posedge CLK);
    #1;
    mode = 3'($urandom);
    address_bridged = $urandom;
    if (early) tx_flag = 1'b0;
    while (cyc < p_done + 1) begin
      @(posedge CLK);
      #1;
    end
    repeat (hold) begin
      @(posedge CLK);
      #1;
    end
    tx_flag = 1'b0;
  endtask

  task automatic xfer(input logic [2:0] md, input logic [31:0] a,
                      input int l, input int hold, input bit early,
                      output int p);
    start_xfer(md, a, l, p);
    finish_xfer(hold, early);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int p;
    int dc;
    int rc;
    logic [2:0] modes [8];
    modes = '{3'b001, 3'b010, 3'b101, 3'b110,
              3'b010, 3'b001, 3'b011, 3'b111};
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;

    ovr_en = 1; ovr_word = 32'hCAFEF00D;
    xfer(3'b010, 32'h0000_0010, 3, 0, 0, p);
    check("dm_lit_data", data_internal, 32'hCAFEF00D);
    check("dm_lit_err", 32'(err), 32'h0);
    check("dm_lit_lat", 32'(last_done - p), 32'd5);
    check("dm_lit_addr", 32'(mem_addr), 32'h4);
    check("dm_lit_sel", 32'(mem_sel), 32'h1);
    ovr_en = 0;

    rf_ovr_en = 1; rf_ovr = 32'h12345678;
    xfer(3'b101, 32'h0000_001F, 1, 0, 0, p);
    check("rf_lit_data", data_internal, 32'h12345678);
    check("rf_lit_idx", 32'(rf_addr), 32'd31);
    check("rf_lit_lat", 32'(last_done - p), 32'd2);
    rf_ovr_en = 0;

    pc_value = 32'h400;
    dc = done_count;
    xfer(3'b110, 32'h0, 1, 20, 0, p);
    check("pc_lit_data", data_internal, 32'h400);
    check("pc_lit_lat", 32'(last_done - p), 32'd1);
    check("hold_one_done", 32'(done_count - dc), 32'd1);
    dc = done_count;
    xfer(3'b010, 32'h0000_0040, 2, 0, 0, p);
    check("rearm_done", 32'(done_count - dc), 32'd1);

    resp_on = 0;
    xfer(3'b001, 32'h0000_0100, 1, 0, 0, p);
    resp_on = 1;
    check("to_lit_data", data_internal, 32'hDEADBEEF);
    check("to_lit_err", 32'(err), 32'h1);
    check("to_lit_lat", 32'(last_done - p), 32'd257);
    xfer(3'b010, 32'h0000_0200, TIMEOUT, 0, 0, p);
    check("last_valid_err", 32'(err), 32'h0);
    xfer(3'b001, 32'h0000_0300, TIMEOUT + 1, 0, 0, p);
    check("late_valid_err", 32'(err), 32'h1);

    rc = rd_count;
    xfer(3'b010, 32'h0000_0003, 1, 0, 0, p);
    check("mis_no_rd", 32'(rd_count - rc), 32'h0);
    check("mis_err", 32'(err), 32'h1);
    xfer(3'b011, 32'h0000_0000, 1, 0, 0, p);
    check("bad_mode_data", data_internal, 32'hDEADBEEF);
    check("bad_mode_err", 32'(err), 32'h1);

    start_xfer(3'b010, 32'h0000_0020, 10, p);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    tx_flag = 1'b0;
    p_done = -1; p_rd = -1; p_rf = -1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    dc = done_count;
    repeat (12) @(posedge CLK);
    #1;
    check("rst_late_valid", 32'(done_count - dc), 32'h0);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]  md;
      logic [31:0] a;
      int          l;
      md = modes[$urandom_range(0, 7)];
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      l = $urandom_range(1, 12);
      if ($urandom_range(0, 39) == 0) l = TIMEOUT + $urandom_range(0, 1);
      resp_on = ($urandom_range(0, 59) != 0);
      pc_value = $urandom;
      xfer(md, a, l, $urandom_range(0, 3), bit'($urandom_range(0, 1)), p);
    end
    resp_on = 1;
    repeat (4) @(posedge CLK);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/debug_bridge.md
Name: debug_bridge

Overview:
- Downstream consumer of the debug controller's transfer request (tx_flag, mode, address_bridged).
- Performs the requested read from instruction memory, data memory, register file or PC while the core is halted.
- Returns the word on data_internal and acknowledges with a one-cycle doneSending pulse.
- Sits between the debug controller and the core's memory and register-file debug ports.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_valid before aborting.
- ERR_WORD, 32'hDEADBEEF: value returned on timeout or unsupported mode.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset; asynchronous, active-low.
- tx_flag  in  1  transfer request from debug controller; level, held until doneSending seen.
- mode  in  3  transfer type: 001 imem read, 010 dmem read, 101 regfile read, 110 PC read; others not serviced.
- address_bridged  in  32  byte address (memories) or register index in [4:0] (regfile).
- data_internal  out  32  read result, held until next completed transfer.
- doneSending  out  1  one-cycle completion pulse.
- err  out  1  sticky: last transfer timed out, was misaligned or used an unsupported mode.
- mem_rd  out  1  memory read strobe, one cycle.
- mem_sel  out  1  0 = instruction memory, 1 = data memory.
- mem_addr  out  30  word address = address_bridged[31:2].
- mem_rdata  in  32  memory read data.
- mem_valid  in  1  mem_rdata valid this cycle; latency 1..TIMEOUT.
- rf_addr  out  5  register-file debug read index.
- rf_rdata  in  32  register-file data, combinational from rf_addr.
- pc_value  in  32  current PC.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE; data_internal=0; doneSending=0; err=0; mem_rd=0; mem_sel=0; mem_addr=0; rf_addr=0; timeout counter=0.
  - Reset mid-transfer abandons the transfer. Late mem_valid after release is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, RFREAD, ACK, HOLD.
- IDLE:
  - tx_flag=1 and mode 001/010 -> ISSUE. Latch mem_sel (mode==010) and mem_addr.
  - tx_flag=1 and mode 101 -> RFREAD. rf_addr <= address_bridged[4:0].
  - tx_flag=1 and mode 110 -> ACK with data_internal <= pc_value, err <= 0.
  - tx_flag=1 and any other mode -> ACK with data_internal <= ERR_WORD, err <= 1.
  - tx_flag=0: stay in IDLE.
- Misaligned memory address (address_bridged[1:0]!=0): no memory access; -> ACK with ERR_WORD, err=1.
- ISSUE: mem_rd=1 for exactly one cycle; counter <= 0; -> WAIT.
- WAIT:
  - mem_valid=1 -> data_internal <= mem_rdata, err <= 0, -> ACK.
  - Else counter++. When counter==TIMEOUT-1 without valid -> data_internal <= ERR_WORD, err <= 1, -> ACK.
  - mem_valid arriving in the same cycle as the timeout: valid wins.
- RFREAD: one cycle for rf_rdata to settle; data_internal <= rf_rdata, err <= 0; -> ACK.
- ACK: doneSending=1 for exactly this cycle; -> HOLD.
- HOLD:
  - Waits for tx_flag=0, then -> IDLE. A level-held tx_flag therefore never triggers a second transfer.
  - Inputs are ignored while in HOLD.
- Latencies from tx_flag rising (sampled in IDLE) to doneSending:
  - PC read: 2 cycles.
  - Regfile read: 3 cycles.
  - Memory read: 3 + memory latency.
- tx_flag dropping before doneSending: the transfer still completes and pulses doneSending, then HOLD returns to IDLE immediately.
- mode and address are captured in IDLE only; changes mid-transfer have no effect.
- data_internal changes only on entry to ACK.
- err updates at each completion and is otherwise held.

Test Plan:
- Reset behaviour: assert RST=0 mid-WAIT -> all outputs 0 and state IDLE. Release reset, then pulse mem_valid -> no doneSending.
- DMEM read: tx_flag=1, mode=010, address=0x0000_0010, memory answers 0xCAFEF00D after 3 cycles.
  -> mem_rd pulse with mem_sel=1, mem_addr=0x4.
  -> data_internal=0xCAFEF00D, one doneSending pulse, err=0.
- Regfile and PC reads:
  - mode=101, address=0x1F, rf_rdata=0x12345678 -> rf_addr=31, data_internal=0x12345678, doneSending 3 cycles after request.
  - mode=110, pc_value=0x400 -> data_internal=0x400 after 2 cycles.
- Timeout: mode=001, mem_valid never asserted -> doneSending after TIMEOUT wait cycles, data_internal=0xDEADBEEF, err=1.
- Error cases:
  - Misaligned address 0x3 with mode 010 -> no mem_rd, err=1.
  - mode=011 -> ERR_WORD returned, err=1.
- Handshake: hold tx_flag=1 for 20 cycles after the PC read completes -> exactly one doneSending pulse. Drop tx_flag, re-raise with mode 010 -> new transfer serviced.
